// File: rtl/pac_dir_ctrl_pkg.sv
// ============================================================================
// pac_pkg : direction types and helpers shared by the Pac-Man movement blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package pac_pkg;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   localparam int GRID_W          = 32;
   localparam int PAC_START_BLOCK = 495;

   // Bit order {up, down, left, right}.
   function automatic logic [3:0] dir_onehot(input dir_t d);
      case (d)
         DIR_UP:    return 4'b1000;
         DIR_DOWN:  return 4'b0100;
         DIR_LEFT:  return 4'b0010;
         DIR_RIGHT: return 4'b0001;
         default:   return 4'b0000;
      endcase
   endfunction

   function automatic dir_t dir_from_keys(input logic [3:0] keys);
      if (keys[3])      return DIR_UP;
      else if (keys[2]) return DIR_DOWN;
      else if (keys[1]) return DIR_LEFT;
      else if (keys[0]) return DIR_RIGHT;
      else              return DIR_NONE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pac_dir_ctrl_debounce.sv
// ============================================================================
// key_debounce : level changes only after CYCLES consecutive differing samples
// Rev 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
   parameter int CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out
);

   localparam int            CW   = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         out <= 1'b0;
      end else if (in != out) begin
         if (cnt == LAST) begin
            out <= in;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         // Any sample agreeing with the current level restarts the run.
         cnt <= '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pac_dir_ctrl.sv
// ============================================================================
// pac_dir_ctrl : latches the requested direction, emits a one-hot move pulse
// once per MOVE_DIV cycles. Optional debouncing: PAC_DIR_DEBOUNCE_EN. Rev 1.0
// ============================================================================
`default_nettype none

module pac_dir_ctrl
   import pac_pkg::*;
#(
   parameter int MOVE_DIV        = 5_000_000,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic key_up,
   input  logic key_down,
   input  logic key_left,
   input  logic key_right,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic move_tick,
   output logic moving
);

   localparam int            CW        = $clog2(MOVE_DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(MOVE_DIV - 1);

   localparam logic [0:0] STATE_IDLE   = 1'b0;
   localparam logic [0:0] STATE_MOVING = 1'b1;

   logic          clear;
   logic [3:0]    key_meta;
   logic [3:0]    k_sync;
   logic [3:0]    keys;
   logic          any_key;
   logic [0:0]    state_q;
   logic [0:0]    state_d;
   logic          moving_d;
   dir_t          dir_q;
   logic [CW-1:0] tick_cnt;
   logic          tick_last;

   assign clear = reset | start;

   always_ff @(posedge clk) begin
      if (clear) begin
         key_meta <= '0;
         k_sync   <= '0;
      end else begin
         key_meta <= {key_up, key_down, key_left, key_right};
         k_sync   <= key_meta;
      end
   end

`ifdef PAC_DIR_DEBOUNCE_EN
   for (genvar i = 0; i < 4; i++) begin : g_debounce
      key_debounce #(
         .CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (clear),
         .in    (k_sync[i]),
         .out   (keys[i])
      );
   end
`else
   // An illegal configuration holds the keys off so the block stays visibly idle.
   if (MOVE_DIV >= 2 && DEBOUNCE_CYCLES >= 1) begin : g_keys_direct
      assign keys = k_sync;
   end else begin : g_keys_blocked
      assign keys = '0;
   end
`endif

   assign any_key = |keys;

   always_ff @(posedge clk) begin
      if (clear) state_q <= STATE_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         STATE_IDLE:   if (any_key) state_d = STATE_MOVING;
         STATE_MOVING: state_d = STATE_MOVING;
         default:      state_d = STATE_IDLE;
      endcase
   end

   always_comb begin
      moving_d = (state_d == STATE_MOVING);
   end

   always_ff @(posedge clk) begin
      if (clear)        dir_q <= DIR_NONE;
      else if (any_key) dir_q <= dir_from_keys(keys);
   end

   assign tick_last = (tick_cnt == TICK_LAST);

   // The pulse reflects dir_q before this edge; a same-edge key change waits a period.
   always_ff @(posedge clk) begin
      if (clear) begin
         tick_cnt                 <= '0;
         move_tick                <= 1'b0;
         moving                   <= 1'b0;
         {up, down, left, right}  <= 4'b0000;
      end else begin
         tick_cnt                 <= tick_last ? '0 : tick_cnt + 1'b1;
         move_tick                <= tick_last;
         moving                   <= moving_d;
         {up, down, left, right}  <= tick_last ? dir_onehot(dir_q) : 4'b0000;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pac_dir_ctrl.sv
// ============================================================================
// tb_pac_dir_ctrl : directed vector table plus randomized run against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pac_dir_ctrl;

   localparam int MOVE_DIV = 4;
   localparam int DB       = 3;
`ifdef PAC_DIR_DEBOUNCE_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif

   localparam logic [3:0] K_UP    = 4'b1000;
   localparam logic [3:0] K_DOWN  = 4'b0100;
   localparam logic [3:0] K_LEFT  = 4'b0010;
   localparam logic [3:0] K_RIGHT = 4'b0001;

   logic clk = 1'b0;
   logic reset, start;
   logic key_up, key_down, key_left, key_right;
   logic up, down, left, right, move_tick, moving;

   pac_dir_ctrl #(
      .MOVE_DIV        (MOVE_DIV),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .key_up    (key_up),
      .key_down  (key_down),
      .key_left  (key_left),
      .key_right (key_right),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .move_tick (move_tick),
      .moving    (moving)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       st;
      logic [3:0] keys;
      logic [3:0] dirs;
      logic       tick;
      logic       mov;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: edges counted since reset, keys delayed two samples.
   int         m_n;
   logic [3:0] m_dir, m_s1, m_ks, m_db, m_out;
   logic       m_tick, m_moving;
   int         m_cnt[4];

   function automatic logic [3:0] highest(input logic [3:0] k);
      for (int b = 3; b >= 0; b--)
         if (k[b]) return 4'(1 << b);
      return 4'b0000;
   endfunction

   function void model_step(input logic r, input logic s, input logic [3:0] k);
      logic [3:0] eff;
      if (r || s) begin
         m_n = 0; m_dir = '0; m_s1 = '0; m_ks = '0; m_db = '0;
         m_out = '0; m_tick = 1'b0; m_moving = 1'b0;
         for (int b = 0; b < 4; b++) m_cnt[b] = 0;
      end else begin
         m_n++;
         m_tick = (m_n % MOVE_DIV == 0);
         m_out  = m_tick ? m_dir : 4'b0000;
         eff    = DB_EN ? m_db : m_ks;
         if (eff != 4'b0000) begin
            m_dir    = highest(eff);
            m_moving = 1'b1;
         end
         for (int b = 0; b < 4; b++) begin
            if (m_ks[b] != m_db[b]) begin
               m_cnt[b]++;
               if (m_cnt[b] == DB) begin
                  m_db[b]  = m_ks[b];
                  m_cnt[b] = 0;
               end
            end else begin
               m_cnt[b] = 0;
            end
         end
         m_ks = m_s1;
         m_s1 = k;
      end
   endfunction

   task automatic apply(input logic r, input logic s, input logic [3:0] k);
      reset = r;
      start = s;
      {key_up, key_down, key_left, key_right} = k;
      @(posedge clk);
      #1;
      model_step(r, s, k);
   endtask

   task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s vec %0d: {tick,moving,u,d,l,r} got %b required %b",
                  name, n_vec, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic [3:0] k,
                      input logic [3:0] d, input logic t, input logic m);
      vec_t v;
      v.rst = r; v.st = s; v.keys = k; v.dirs = d; v.tick = t; v.mov = m;
      tbl.push_back(v);
   endtask

   // Cycles c0..c1 after reset: tick on multiples of MOVE_DIV carrying direction d.
   task automatic fill(input int c0, input int c1, input logic [3:0] k,
                       input logic [3:0] d, input logic m);
      for (int c = c0; c <= c1; c++)
         add(1'b0, 1'b0, k, (c % MOVE_DIV == 0) ? d : 4'b0000, (c % MOVE_DIV == 0), m);
   endtask

   logic [3:0] cur_keys;
   logic       r_rand, s_rand;

   initial begin
      reset = 1'b1; start = 1'b0;
      {key_up, key_down, key_left, key_right} = 4'b0000;
      model_step(1'b1, 1'b0, 4'b0000);

`ifndef PAC_DIR_DEBOUNCE_EN
      // Idle after reset: bare ticks, nothing moving.
      add(1, 0, 0, 0, 0, 0); fill(1, 12, 0, 0, 0);
      // One-cycle right press persists.
      add(1, 0, 0, 0, 0, 0); fill(1, 1, K_RIGHT, 0, 0); fill(2, 2, 0, 0, 0);
      fill(3, 13, 0, K_RIGHT, 1);
      // Up beats left; releasing up hands over to left.
      add(1, 0, 0, 0, 0, 0); fill(1, 2, K_UP | K_LEFT, 0, 0);
      fill(3, 4, K_UP | K_LEFT, K_UP, 1); fill(5, 12, K_LEFT, K_LEFT, 1);
      // Down lands in dir_q on a tick edge: old direction first.
      add(1, 0, 0, 0, 0, 0); fill(1, 1, K_RIGHT, 0, 0); fill(2, 2, 0, 0, 0);
      fill(3, 5, 0, K_RIGHT, 1); fill(6, 6, K_DOWN, K_RIGHT, 1);
      fill(7, 8, 0, K_RIGHT, 1); fill(9, 12, 0, K_DOWN, 1);
      // Start mid-period restarts timing and forgets the direction.
      add(1, 0, 0, 0, 0, 0); fill(1, 1, K_RIGHT, 0, 0); fill(2, 2, 0, 0, 0);
      fill(3, 5, 0, K_RIGHT, 1); add(0, 1, 0, 0, 0, 0); fill(1, 8, 0, 0, 0);
      // Reset and start together on a tick edge.
      add(1, 0, 0, 0, 0, 0); fill(1, 1, K_RIGHT, 0, 0); fill(2, 2, 0, 0, 0);
      fill(3, 3, 0, K_RIGHT, 1); add(1, 1, 0, 0, 0, 0); fill(1, 4, 0, 0, 0);
`else
      // Bouncing up key never settles; a steady press lands six cycles later.
      add(1, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 10; c++)
         add(0, 0, (c % 2 == 1) ? K_UP : 4'b0000, 0, (c % MOVE_DIV == 0), 0);
      fill(11, 14, 0, 0, 0); fill(15, 19, K_UP, 0, 0);
      fill(20, 20, K_UP, 0, 1); fill(21, 25, K_UP, K_UP, 1);
`endif

      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].st, tbl[i].keys);
         check("table", {move_tick, moving, up, down, left, right},
               {tbl[i].tick, tbl[i].mov, tbl[i].dirs});
      end

      apply(1'b1, 1'b0, 4'b0000);
      cur_keys = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0)
            cur_keys = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
         r_rand = ($urandom_range(0, 299) == 0);
         s_rand = ($urandom_range(0, 199) == 0);
         apply(r_rand, s_rand, cur_keys);
         check("random", {move_tick, moving, up, down, left, right},
               {m_tick, m_moving, m_out});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
